nibble_word_serializer: RTL and testbench
=========================================

Name: nibble_word_serializer

Overview:
- Parallel-to-nibble-serial feeder for the nibble-serial ALU datapath.
- Accepts an operand pair of 32-bit words, a direction and a carry seed over a valid/ready handshake.
- Emits the eight nibble pairs one beat at a time over a second valid/ready handshake. Order is LSB-first or MSB-first.
- It is the producer end of the nibble stream that the nibble loop/ALU consumes and reassembles into a word.

Parameters:
- WORD_W, 32: operand width. Must be a multiple of 4. NIBBLES = WORD_W/4; index width IDX_W = $clog2(NIBBLES), which is 3 by default.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous reset, active-low
- in_valid  input  1  operand pair offered
- in_ready  output  1  serializer can accept an operand pair this cycle
- in_word1  input  WORD_W  first operand
- in_word2  input  WORD_W  second operand
- in_direction  input  1  0 = LSB nibble first; 1 = MSB nibble first (reverse)
- in_carry  input  1  carry/shift seed for the ALU
- out_valid  output  1  nibble beat valid
- out_ready  input  1  consumer accepts the beat
- out_d1  output  4  current nibble of word1
- out_d2  output  4  current nibble of word2
- out_idx  output  IDX_W  nibble index of the current beat
- out_first  output  1  first beat of the word
- out_last  output  1  last beat of the word
- out_carry_seed  output  1  latched in_carry, held for the whole word
- busy  output  1  transfer in progress (equals out_valid)

Behaviour:
- States: IDLE and SHIFT.
- Reset (reset_n low, asynchronous): state=IDLE, out_valid=0, busy=0, out_idx=0, out_first=0, out_last=0, out_carry_seed=0, out_d1=0, out_d2=0, internal word registers=0. While reset_n is low, in_ready=0.
- in_ready (combinational) = reset_n && ((state==IDLE) || (out_valid && out_ready && out_last)).
- Accept: in_valid && in_ready at a rising edge.
  - Latches word1, word2, direction and carry.
  - Sets out_idx to 0 (direction 0) or NIBBLES-1 (direction 1).
  - Enters SHIFT with out_valid=1 on the next cycle. Latency from accept edge to first beat is 1 cycle.
- Beat transfer: out_valid && out_ready at an edge.
  - Not last beat: out_idx steps +1 (direction 0) or -1 (direction 1).
  - Last beat with no new accept at the same edge: go to IDLE, out_valid=0.
  - Last beat with a new accept at the same edge: load the new word and idx, stay in SHIFT. out_valid stays 1, so there is no bubble.
- Stall (out_valid && !out_ready): every out_* signal holds stable. No index change.
- Outputs:
  - out_d1 = word1_reg[out_idx*4 +: 4] and out_d2 = word2_reg[out_idx*4 +: 4]. Both are combinational from registers (no extra latency).
  - out_first is high when out_idx equals the start index.
  - out_last is high when out_idx == NIBBLES-1 (direction 0) or == 0 (direction 1).
  - out_first and out_last are asserted only while out_valid=1.
- Input changes: in_word1, in_word2, in_direction and in_carry are ignored except at an accept edge.
- Index bounds: the index never wraps. A word is exactly NIBBLES beats.
- Reset mid-transfer: the word is aborted and all outputs drop to reset values immediately. After release, in_ready=1 from the next cycle and the next transfer starts clean.
- in_valid while busy and not on the last accepted beat: the serializer does not consume it (in_ready=0). The producer must hold it.

Test Plan:
1. Forward transfer.
   - Stimulus: word1=32'hEFFF_FFFF, word2=32'h0000_0001, dir=0, carry=0, out_ready=1.
   - Expected: beats idx 0..7. out_d1 = F,F,F,F,F,F,F,E. out_d2 = 1,0,0,0,0,0,0,0. out_first only on beat 0, out_last only on beat 7. in_ready low on beats 0-6.
2. Reverse transfer.
   - Stimulus: word1=0, word2=32'h0600_0000, dir=1, carry=1.
   - Expected: idx 7,6,...,0. out_d2 = 0,6,0,0,0,0,0,0. out_carry_seed=1 on all 8 beats. out_last on idx 0.
3. Backpressure.
   - Stimulus: word1=32'hFFFF_0FFF, dir=0; out_ready pattern 1,0,0,1,1,0,1,...
   - Expected: out_d1, out_idx and out_first/out_last frozen during ready=0. Each nibble is delivered exactly once. Total accepted beats = 8, d1 sequence F,F,F,0,F,F,F,F.
4. Back-to-back.
   - Stimulus: second pair (32'h1234_5678, 32'h0) offered during beat 7 of the first, out_ready=1.
   - Expected: accepted on the last-beat edge. out_valid stays high for 16 consecutive cycles. The second word's d1 = 8,7,6,5,4,3,2,1.
5. Reset mid-stream.
   - Stimulus: assert reset_n=0 asynchronously (between edges) during beat 3.
   - Expected: out_valid=0 immediately, before the next edge. After release, in_ready=1, and a new pair starts at idx 0 with out_first=1.
6. Input isolation.
   - Stimulus: change in_word1/in_direction every cycle during SHIFT with in_valid=0.
   - Expected: output nibbles match only the latched word. No extra accept occurs.

Source files
------------

// File: rtl/nibble_word_serializer.sv
// Purpose : splits an operand pair of WORD_W-bit words into NIBBLES nibble-pair
//           beats, LSB-first or MSB-first, for the nibble-serial ALU datapath.
// Latency : first beat is valid one cycle after the accept edge. A new pair
//           accepted on the last-beat edge follows with no bubble.
// Backpressure: while out_valid && !out_ready every out_* holds. in_ready is
//           only high when idle or when the final beat is leaving this cycle.
//
// Ports:
//   clk, reset_n                : rising-edge clock, async active-low reset
//   in_valid/in_ready           : operand-pair handshake
//   in_word1, in_word2          : operands, sampled only at the accept edge
//   in_direction                : 0 = LSB nibble first, 1 = MSB nibble first
//   in_carry                    : carry/shift seed, held as out_carry_seed
//   out_valid/out_ready         : nibble-beat handshake
//   out_d1, out_d2              : current nibble of each operand
//   out_idx                     : nibble index of the current beat
//   out_first, out_last         : word boundary markers (only while valid)
//   out_carry_seed              : latched carry seed for the whole word
//   busy                        : transfer in progress (same as out_valid)
module nibble_word_serializer #(
  parameter int  WORD_W  = 32,
  localparam int NIBBLES = WORD_W / 4,
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word1,
  input  logic [WORD_W-1:0] in_word2,
  input  logic              in_direction,
  input  logic              in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_d1,
  output logic [3:0]        out_d2,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_first,
  output logic              out_last,
  output logic              out_carry_seed,
  output logic              busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);

  logic [0:0]        state_q, state_d;
  logic [WORD_W-1:0] w1_q, w1_d;
  logic [WORD_W-1:0] w2_q, w2_d;
  logic              dir_q, dir_d;
  logic              carry_q, carry_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic              at_first;
  logic              at_last;
  logic              accept;
  logic              beat;
  logic [WORD_W-1:0] w1_sh;
  logic [WORD_W-1:0] w2_sh;

  // Start/end index depend on the latched direction, not the live input.
  assign at_first = dir_q ? (idx_q == IDX_TOP) : (idx_q == '0);
  assign at_last  = dir_q ? (idx_q == '0)      : (idx_q == IDX_TOP);

  assign out_valid      = (state_q == ST_SHIFT);
  assign busy           = out_valid;
  assign out_first      = out_valid && at_first;
  assign out_last       = out_valid && at_last;
  assign out_idx        = idx_q;
  assign out_carry_seed = carry_q;

  // Nibble select by shifting the held word; purely combinational from regs.
  assign w1_sh  = w1_q >> {idx_q, 2'b00};
  assign w2_sh  = w2_q >> {idx_q, 2'b00};
  assign out_d1 = w1_sh[3:0];
  assign out_d2 = w2_sh[3:0];

  // Ready either when idle or when the last beat is draining this edge, which
  // lets a new pair load with no idle cycle between words.
  assign in_ready = reset_n && ((state_q == ST_IDLE) || (out_valid && out_ready && at_last));
  assign accept   = in_valid && in_ready;
  assign beat     = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    dir_d   = dir_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    if (accept) begin
      // Covers both the idle load and the back-to-back load on the last beat.
      state_d = ST_SHIFT;
      w1_d    = in_word1;
      w2_d    = in_word2;
      dir_d   = in_direction;
      carry_d = in_carry;
      idx_d   = in_direction ? IDX_TOP : '0;
    end else if (beat) begin
      if (at_last) begin
        state_d = ST_IDLE;
      end else if (dir_q) begin
        idx_d = idx_q - IDX_W'(1);
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      w1_q    <= '0;
      w2_q    <= '0;
      dir_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      dir_q   <= dir_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_nibble_word_serializer.sv
// Purpose : self-checking bench for nibble_word_serializer against a
//           queue-of-beats reference model plus literal word-level pins.
// Latency : model expects first beat one cycle after accept, no bubble b2b.
// Backpressure: out_ready driven fixed, patterned or random per test.
module tb_nibble_word_serializer;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d2;
    logic [2:0] idx;
    logic       first;
    logic       last;
    logic       carry;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word1;
  logic [31:0] in_word2;
  logic        in_direction;
  logic        in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_d1;
  logic [3:0]  out_d2;
  logic [2:0]  out_idx;
  logic        out_first;
  logic        out_last;
  logic        out_carry_seed;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  beat_t       mq[$];
  int          out_mode = 0;
  int          pc = 0;
  logic [6:0]  ready_pat = 7'b1011001;  // 1,0,0,1,1,0,1 from bit 0 upward

  logic [31:0] seq_d1, seq_d2;
  int          nbeats, run, maxrun;

  logic        stall_prev = 1'b0;
  beat_t       prev_out;

  nibble_word_serializer #(.WORD_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_word1(in_word1), .in_word2(in_word2),
    .in_direction(in_direction), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d1(out_d1), .out_d2(out_d2), .out_idx(out_idx),
    .out_first(out_first), .out_last(out_last),
    .out_carry_seed(out_carry_seed), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // A word becomes exactly eight beats; nibble k of the stream is word
  // nibble k (forward) or 7-k (reverse).
  task automatic push_word(input logic [31:0] a, input logic [31:0] b,
                           input logic dir, input logic c);
    for (int k = 0; k < 8; k++) begin
      beat_t bt;
      int    ix;
      ix       = dir ? (7 - k) : k;
      bt.d1    = 4'((a >> (4 * ix)) & 32'hF);
      bt.d2    = 4'((b >> (4 * ix)) & 32'hF);
      bt.idx   = 3'(ix);
      bt.first = (k == 0);
      bt.last  = (k == 7);
      bt.carry = c;
      mq.push_back(bt);
    end
  endtask

  // Consumer-side ready generator.
  always @(posedge clk) begin
    #1;
    if (out_mode == 1) begin
      out_ready = ready_pat[pc % 7];
      pc++;
    end else begin
      pc = 0;
      if (out_mode == 2) out_ready = 1'($urandom_range(0, 1));
      else               out_ready = 1'b1;
    end
  end

  // Compare process: all inputs are stable around the falling edge, so the
  // model can also decide what happens at the next rising edge.
  always @(negedge clk) begin
    beat_t cur;
    logic  exp_valid, exp_rdy;
    cur = '{d1: out_d1, d2: out_d2, idx: out_idx, first: out_first,
            last: out_last, carry: out_carry_seed};
    if (!reset_n) begin
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_busy",      {31'b0, busy}, 32'd0);
      chk("rst_in_ready",  {31'b0, in_ready}, 32'd0);
      chk("rst_outputs",   {18'b0, cur}, 32'd0);
      mq.delete();
      stall_prev = 1'b0;
    end else begin
      exp_valid = (mq.size() != 0);
      exp_rdy   = (mq.size() == 0) || (mq.size() == 1 && out_ready);
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      chk("busy",      {31'b0, busy}, {31'b0, exp_valid});
      chk("in_ready",  {31'b0, in_ready}, {31'b0, exp_rdy});
      if (exp_valid) begin
        chk("beat", {18'b0, cur}, {18'b0, mq[0]});
      end else begin
        chk("idle_marks", {30'b0, out_first, out_last}, 32'd0);
      end
      if (stall_prev) chk("stall_hold", {18'b0, cur}, {18'b0, prev_out});
      stall_prev = out_valid && !out_ready;
      prev_out   = cur;

      if (out_valid && out_ready) begin
        seq_d1 = {out_d1, seq_d1[31:4]};
        seq_d2 = {out_d2, seq_d2[31:4]};
        nbeats++;
      end
      if (out_valid) run++;
      else           run = 0;
      if (run > maxrun) maxrun = run;

      if (exp_valid && out_ready) void'(mq.pop_front());
      if (in_valid && exp_rdy) push_word(in_word1, in_word2, in_direction, in_carry);
    end
  end

  task automatic clear_log();
    seq_d1 = '0; seq_d2 = '0; nbeats = 0; run = 0; maxrun = 0;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] b,
                       input logic dir, input logic c);
    logic acc;
    logic done;
    done = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_word1 = a; in_word2 = b; in_direction = dir; in_carry = c;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    chk("accept_timeout", {31'b0, done}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!out_valid && mq.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("idle_timeout", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_word1 = '0; in_word2 = '0;
    in_direction = 1'b0; in_carry = 1'b0; out_ready = 1'b1;
    clear_log();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 chk("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

    // 1. Forward transfer
    clear_log();
    offer(32'hEFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_idle();
    chk("fwd_d1_seq", seq_d1, 32'hEFFF_FFFF);
    chk("fwd_d2_seq", seq_d2, 32'h0000_0001);
    chk("fwd_beats", nbeats, 32'd8);

    // 2. Reverse transfer (d2 stream 0,6,0,... packed first-beat-lowest)
    clear_log();
    offer(32'h0, 32'h0600_0000, 1'b1, 1'b1);
    wait_idle();
    chk("rev_d2_seq", seq_d2, 32'h0000_0060);
    chk("rev_d1_seq", seq_d1, 32'h0000_0000);
    chk("rev_beats", nbeats, 32'd8);

    // 3. Backpressure with a fixed ready pattern
    out_mode = 1;
    clear_log();
    offer(32'hFFFF_0FFF, 32'h0, 1'b0, 1'b0);
    wait_idle();
    chk("bp_d1_seq", seq_d1, 32'hFFFF_0FFF);
    chk("bp_beats", nbeats, 32'd8);
    out_mode = 0;
    repeat (2) @(posedge clk);

    // 4. Back-to-back: second pair held until the last-beat edge
    clear_log();
    offer(32'hCAFE_F00D, 32'h1111_2222, 1'b0, 1'b0);
    offer(32'h1234_5678, 32'h0, 1'b0, 1'b0);
    wait_idle();
    chk("b2b_run", maxrun, 32'd16);
    chk("b2b_beats", nbeats, 32'd16);
    chk("b2b_d1_seq", seq_d1, 32'h1234_5678);

    // 5. Asynchronous reset mid-stream
    offer(32'h8765_4321, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (out_valid && out_idx == 3'd3) break;
    end
    chk("reach_beat3", {29'b0, out_idx}, 32'd3);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("async_rst_carry", {31'b0, out_carry_seed}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    #1 chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    clear_log();
    offer(32'h0F0F_0F0F, 32'hA5A5_A5A5, 1'b0, 1'b0);
    #1 chk("post_rst_first", {29'b0, out_idx, out_first}, 32'd1);
    wait_idle();
    chk("post_rst_beats", nbeats, 32'd8);

    // 6. Input isolation: inputs wiggle while shifting, in_valid low
    clear_log();
    offer(32'hA5C3_9F10, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (!out_valid) break;
      in_word1 = $urandom; in_word2 = $urandom;
      in_direction = ~in_direction; in_carry = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    wait_idle();
    chk("iso_d1_seq", seq_d1, 32'hA5C3_9F10);
    chk("iso_beats", nbeats, 32'd8);

    // Randomized traffic with random backpressure and random gaps
    out_mode = 2;
    for (int n = 0; n < 30; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      offer($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    out_mode = 0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
